// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that merges several valid/ready word streams into one registered output.
// Each grant is held for a whole packet, or until MaxBeats words have passed and the grant is released by force.
module stream_rr_arbiter #(
    parameter int Width    = 32,
    parameter int Ports    = 4,
    parameter int MaxBeats = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [Ports-1:0]           ACTL,
    input  logic [Ports-1:0]           LASTL,
    input  logic [Ports*Width-1:0]     DI,
    output logic [Ports-1:0]           NEXTL,
    output logic                       ACTH,
    input  logic                       NEXTH,
    output logic [Width-1:0]           DO,
    output logic                       LASTH,
    output logic [$clog2(Ports)-1:0]   SRC,
    output logic                       FORCED
);

    localparam int SW = $clog2(Ports);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_next;
    logic [SW-1:0]   grant, grant_next;
    logic [SW-1:0]   ptr, ptr_next;
    logic [SW-1:0]   pick, cand, grant_inc;
    logic [7:0]      cnt, cnt_next;
    logic            any_req, free, take, release_forced, limit;
    logic            grant_act, grant_last;
    logic [Width-1:0] grant_data;

    assign free      = ~ACTH | NEXTH;
    assign grant_inc = (grant == SW'(Ports - 1)) ? '0 : grant + SW'(1);
    assign limit     = ({1'b0, cnt} + 9'd1) == 9'(MaxBeats);

    // Descending search so the candidate nearest to ptr is the one left standing.
    always_comb begin
        pick    = ptr;
        any_req = 1'b0;
        cand    = '0;
        for (int k = Ports - 1; k >= 0; k--) begin
            cand = SW'((int'(ptr) + k) % Ports);
            if (ACTL[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        grant_act  = 1'b0;
        grant_last = 1'b0;
        grant_data = '0;
        for (int i = 0; i < Ports; i++) begin
            if (grant == SW'(i)) begin
                grant_act  = ACTL[i];
                grant_last = LASTL[i];
                grant_data = DI[i*Width +: Width];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        grant_next     = grant;
        ptr_next       = ptr;
        cnt_next       = cnt;
        NEXTL          = '0;
        take           = 1'b0;
        release_forced = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_next = pick;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < Ports; i++) begin
                    NEXTL[i] = (grant == SW'(i)) & free;
                end
                take = grant_act & free;
                if (take) begin
                    cnt_next = cnt + 8'd1;
                    if (grant_last || limit) begin
                        ptr_next       = grant_inc;
                        state_next     = IDLE;
                        release_forced = ~grant_last;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Nothing may be accepted while reset is held, even combinationally.
        if (RESET) begin
            NEXTL          = '0;
            take           = 1'b0;
            release_forced = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DO     <= '0;
            LASTH  <= 1'b0;
            SRC    <= '0;
            ACTH   <= 1'b0;
            FORCED <= 1'b0;
        end else begin
            FORCED <= release_forced;
            if (take) begin
                DO    <= grant_data;
                LASTH <= grant_last;
                SRC   <= grant;
                ACTH  <= 1'b1;
            end else if (NEXTH) begin
                ACTH <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: per-port source queues feed the DUT,
// a negedge monitor pops hand-computed expected words on every output transfer.
module tb_stream_rr_arbiter;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [1:0]  src;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  ACTL, LASTL, NEXTL;
    logic [63:0] DI;
    logic        ACTH, NEXTH, LASTH, FORCED;
    logic [15:0] DO;
    logic [1:0]  SRC;

    exp_t        exp_q[$];
    logic [16:0] q0[$], q1[$], q2[$], q3[$];
    int          out_cyc[$];
    int          tests = 0, fails = 0, cyc = 0;
    int          out_count = 0, in_count = 0, forced_count = 0;

    stream_rr_arbiter #(.Width(16), .Ports(4), .MaxBeats(4)) dut (
        .CLK(CLK), .RESET(RESET), .ACTL(ACTL), .LASTL(LASTL), .DI(DI),
        .NEXTL(NEXTL), .ACTH(ACTH), .NEXTH(NEXTH), .DO(DO), .LASTH(LASTH),
        .SRC(SRC), .FORCED(FORCED)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [15:0] data, input logic last);
        case (port)
            0: q0.push_back({last, data});
            1: q1.push_back({last, data});
            2: q2.push_back({last, data});
            default: q3.push_back({last, data});
        endcase
    endtask

    task automatic expectWord(input logic [15:0] data, input logic last, input logic [1:0] src);
        exp_t e;
        e = {data, last, src};
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic waitDrain(input string name, input int bound, input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            if (rnd) NEXTH = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        NEXTH = 1'b1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_drain: %0d words outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    // Sources: acceptance is sampled at negedge, queues advance just after the edge.
    initial begin
        logic [3:0]  acc;
        logic [16:0] dummy;
        ACTL  = '0;
        LASTL = '0;
        DI    = '0;
        forever begin
            @(negedge CLK);
            acc = ACTL & NEXTL;
            @(posedge CLK);
            #1;
            if (acc[0]) begin dummy = q0.pop_front(); in_count++; end
            if (acc[1]) begin dummy = q1.pop_front(); in_count++; end
            if (acc[2]) begin dummy = q2.pop_front(); in_count++; end
            if (acc[3]) begin dummy = q3.pop_front(); in_count++; end
            ACTL[0] = q0.size() != 0;
            ACTL[1] = q1.size() != 0;
            ACTL[2] = q2.size() != 0;
            ACTL[3] = q3.size() != 0;
            {LASTL[0], DI[15:0]}  = (q0.size() != 0) ? q0[0] : 17'b0;
            {LASTL[1], DI[31:16]} = (q1.size() != 0) ? q1[0] : 17'b0;
            {LASTL[2], DI[47:32]} = (q2.size() != 0) ? q2[0] : 17'b0;
            {LASTL[3], DI[63:48]} = (q3.size() != 0) ? q3[0] : 17'b0;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (FORCED === 1'b1) forced_count++;
            if (!RESET && ACTH && NEXTH) begin
                out_count++;
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_word: got %0h/%0b/%0d, want none", DO, LASTH, SRC);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_word", {13'b0, DO, LASTH, SRC}, {13'b0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int in0, out0;
        int n;
        logic [15:0] d;
        RESET = 1'b1;
        NEXTH = 1'b1;
        repeat (3) step();
        checkOutput("reset_nextl", 32'(NEXTL), 32'h0);
        RESET = 1'b0;
        step();
        checkOutput("reset_acth", 32'(ACTH), 32'h0);
        checkOutput("reset_do", 32'(DO), 32'h0);
        checkOutput("reset_src_last", 32'({SRC, LASTH}), 32'h0);
        checkOutput("reset_forced", 32'(FORCED), 32'h0);

        // Two single-word requesters alternate, each grant behind an idle cycle.
        out_cyc.delete();
        applyStimulus(0, 16'h0A01, 1'b1);
        applyStimulus(0, 16'h0A02, 1'b1);
        applyStimulus(2, 16'h0C01, 1'b1);
        applyStimulus(2, 16'h0C02, 1'b1);
        expectWord(16'h0A01, 1'b1, 2'd0);
        expectWord(16'h0C01, 1'b1, 2'd2);
        expectWord(16'h0A02, 1'b1, 2'd0);
        expectWord(16'h0C02, 1'b1, 2'd2);
        waitDrain("alt", 40, 1'b0);
        checkOutput("alt_count", 32'(out_cyc.size()), 32'd4);
        if (out_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                checkOutput("alt_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'd2);

        // Three-word packet streams back to back.
        out_cyc.delete();
        applyStimulus(1, 16'h1A1A, 1'b0);
        applyStimulus(1, 16'h1B1B, 1'b0);
        applyStimulus(1, 16'h1C1C, 1'b1);
        expectWord(16'h1A1A, 1'b0, 2'd1);
        expectWord(16'h1B1B, 1'b0, 2'd1);
        expectWord(16'h1C1C, 1'b1, 2'd1);
        waitDrain("pkt", 40, 1'b0);
        checkOutput("pkt_count", 32'(out_cyc.size()), 32'd3);
        if (out_cyc.size() == 3)
            for (int i = 1; i < 3; i++)
                checkOutput("pkt_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);

        // Pointer now at 2: order 2,3 then wrap to 0,1.
        for (int i = 0; i < 4; i++) applyStimulus(i, 16'h2000 + 16'(i), 1'b1);
        expectWord(16'h2002, 1'b1, 2'd2);
        expectWord(16'h2003, 1'b1, 2'd3);
        expectWord(16'h2000, 1'b1, 2'd0);
        expectWord(16'h2001, 1'b1, 2'd1);
        waitDrain("wrap", 60, 1'b0);

        // Downstream stall for 5 cycles; LAST coincides with the beat limit.
        forced_count = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 16'h3000 + 16'(i), i == 3);
            expectWord(16'h3000 + 16'(i), i == 3, 2'd0);
        end
        n = 0;
        while (!ACTH && n < 20) begin step(); n++; end
        checkOutput("stall_acth_up", 32'(ACTH), 32'h1);
        NEXTH = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("stall_acth", 32'(ACTH), 32'h1);
            checkOutput("stall_do", 32'(DO), 32'h3000);
            checkOutput("stall_nextl", 32'(NEXTL), 32'h0);
        end
        NEXTH = 1'b1;
        waitDrain("stall", 40, 1'b0);
        checkOutput("last_at_limit_forced", 32'(forced_count), 32'd0);

        // Six words without LAST: forced release after 4, then re-grant, then an indefinite hold.
        forced_count = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3, 16'h4000 + 16'(i), 1'b0);
            expectWord(16'h4000 + 16'(i), 1'b0, 2'd3);
        end
        waitDrain("limit", 60, 1'b0);
        checkOutput("limit_forced_pulses", 32'(forced_count), 32'd1);
        applyStimulus(0, 16'h5000, 1'b1);
        repeat (4) step();
        checkOutput("held_nextl", 32'(NEXTL), 32'h8);
        checkOutput("held_req0_waiting", 32'(q0.size()), 32'd1);
        checkOutput("held_acth", 32'(ACTH), 32'h0);

        // Reset breaks the held grant; requester 0 then wins from pointer 0.
        RESET = 1'b1;
        #1;
        checkOutput("rst_nextl", 32'(NEXTL), 32'h0);
        step();
        RESET = 1'b0;
        checkOutput("rst_acth", 32'(ACTH), 32'h0);
        expectWord(16'h5000, 1'b1, 2'd0);
        waitDrain("rst_hold", 40, 1'b0);

        // Reset after two of four words: the second word is dropped from the output register.
        applyStimulus(2, 16'h5A00, 1'b0);
        applyStimulus(2, 16'h5A01, 1'b0);
        applyStimulus(2, 16'h5A02, 1'b0);
        applyStimulus(2, 16'h5A03, 1'b1);
        expectWord(16'h5A00, 1'b0, 2'd2);
        repeat (4) step();
        checkOutput("mid_do", 32'(DO), 32'h5A01);
        applyStimulus(1, 16'h5100, 1'b1);
        applyStimulus(3, 16'h5300, 1'b1);
        RESET = 1'b1;
        #1;
        checkOutput("mid_rst_nextl", 32'(NEXTL), 32'h0);
        step();
        RESET = 1'b0;
        checkOutput("mid_rst_acth", 32'(ACTH), 32'h0);
        checkOutput("mid_rst_do", 32'(DO), 32'h0);
        expectWord(16'h5100, 1'b1, 2'd1);
        expectWord(16'h5A02, 1'b0, 2'd2);
        expectWord(16'h5A03, 1'b1, 2'd2);
        expectWord(16'h5300, 1'b1, 2'd3);
        waitDrain("mid_rst", 60, 1'b0);

        // All ports busy with random downstream ready: strict 0,1,2,3 rotation.
        in0  = in_count;
        out0 = out_count;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                d = 16'h6000 + 16'(i * 16 + k);
                applyStimulus(i, d, 1'b1);
                expectWord(d, 1'b1, 2'(i));
            end
        waitDrain("fair", 400, 1'b1);
        checkOutput("fair_out_count", 32'(out_count - out0), 32'd12);
        checkOutput("fair_in_count", 32'(in_count - in0), 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 The module SHALL have parameter Width, default 32, giving the data width in bits.
REQ-002 The module SHALL have parameter Ports, default 4, giving the number of requesters (2..8).
REQ-003 The module SHALL have parameter MaxBeats, default 16, giving the maximum words per grant before a forced release (1..255).
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-005 The module SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port ACTL, input, Ports bits: per-requester word valid.
REQ-007 The module SHALL have port LASTL, input, Ports bits: per-requester end-of-packet, qualified by ACTL.
REQ-008 The module SHALL have port DI, input, Ports*Width bits: per-requester data; requester i uses bits [i*Width +: Width].
REQ-009 The module SHALL have port NEXTL, output, Ports bits: per-requester ready; a word transfers when ACTL[i] & NEXTL[i].
REQ-010 The module SHALL have port ACTH, output, 1 bit: output word valid.
REQ-011 The module SHALL have port NEXTH, input, 1 bit: downstream ready; an output transfer happens when ACTH & NEXTH.
REQ-012 The module SHALL have port DO, output, Width bits: registered output data.
REQ-013 The module SHALL have port LASTH, output, 1 bit: registered end-of-packet, aligned with DO.
REQ-014 The module SHALL have port SRC, output, clog2(Ports) bits: registered index of the requester that supplied DO.
REQ-015 The module SHALL have port FORCED, output, 1 bit: one-cycle pulse when a grant is released by the MaxBeats limit.

Function
REQ-016 State SHALL be IDLE or GRANT; the registered grant index is G; the round-robin pointer is P; the beat counter is Cnt (8 bits).
REQ-017 Free is defined as ~ACTH | NEXTH; the output register SHALL load only when Free is 1.
REQ-018 In IDLE with any ACTL bit set, the block SHALL select the first set index searching P, P+1, ... modulo Ports, load G, clear Cnt, and enter GRANT on the next edge.
REQ-019 In IDLE, NEXTL SHALL be all zeros; arbitration costs exactly one cycle.
REQ-020 In GRANT, NEXTL[G] SHALL equal Free, and all other NEXTL bits SHALL be 0.
REQ-021 On a transfer from G, DO, LASTH and SRC SHALL load DI[G], LASTL[G] and G; ACTH SHALL be 1 on the next cycle, giving one-cycle input-to-output latency.
REQ-022 ACTH SHALL clear when NEXTH=1 and no new word loads in that cycle; DO, LASTH and SRC SHALL hold while ACTH & ~NEXTH.
REQ-023 Each transfer in GRANT SHALL increment Cnt.
REQ-024 A transfer with LASTL[G]=1 SHALL set P to (G+1) mod Ports and return to IDLE.
REQ-025 A transfer with LASTL[G]=0 and Cnt+1 = MaxBeats SHALL also set P to (G+1) mod Ports, return to IDLE, and pulse FORCED for one cycle.
REQ-026 When LAST and the MaxBeats limit occur together, the release SHALL be treated as normal: FORCED=0.
REQ-027 In GRANT with ACTL[G]=0, the grant SHALL be held indefinitely; there is no timeout.
REQ-028 Wrap-around: when G = Ports-1, P SHALL become 0.
REQ-029 Requesters other than G SHALL never be accepted, even if the output register is Free.
REQ-030 Downstream stall SHALL back-pressure only G; no word SHALL be lost or duplicated.

Reset
REQ-031 While RESET=1, at each edge: state=IDLE, P=0, G=0, Cnt=0, ACTH=0, LASTH=0, SRC=0, DO=0, FORCED=0; NEXTL SHALL be 0 combinationally during RESET.
REQ-032 RESET mid-packet SHALL abandon the grant and drop the output word; the first post-reset arbitration SHALL start from P=0.

Verification
REQ-033 Apply ACTL=0101, all LAST=1, NEXTH=1 -> words are granted in order 0, 2, 0, 2; each grant is preceded by one IDLE cycle.
REQ-034 Requester 1 sends a 3-word packet A,B,C (LAST on C) with NEXTH=1 -> DO shows A,B,C on consecutive cycles with SRC=1 and LASTH=1 only with C; afterwards P=2.
REQ-035 Hold NEXTH=0 for 5 cycles during a packet -> ACTH stays 1, DO is stable, NEXTL[G]=0; when NEXTH returns, the stream resumes without loss.
REQ-036 MaxBeats=4, requester 3 streams 6 words without LAST -> 4 words are accepted, FORCED pulses, P=0, then requester 3 is re-granted (sole requester) for the remaining 2 words.
REQ-037 Assert RESET for 1 cycle after 2 of 4 words -> ACTH=0 the next cycle, NEXTL=0 during reset, and re-arbitration starts from index 0.
REQ-038 All ports request continuously with random NEXTH -> each port receives a grant within Ports grants (fairness), and the output word count equals the input transfer count.
